lsu_mem_stage: RTL

Load/store unit sitting directly downstream of the ALU in the RISC-V core: takes the ALU-computed effective address, the store data (rs2) and funct3, runs one access on the data-memory bus with a req/gnt/rvalid handshake, and returns sign/zero-extended load data for the writeback mux (mem_to_reg path). Asserts `busy` to stall PC update while an access is in flight. Detects illegal size encodings, misaligned addresses and bus timeouts.

---
 rtl/lsu_mem_stage_if.sv | 41 ++++
 rtl/lsu_mem_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage_if.sv
// lsu_mem_stage_if: bundles the execute-side request/response handshake and the
// data-memory req/gnt/rvalid bus of the load/store unit.
//   master : the LSU (drives req_ready, rsp_*, busy, mem_req/we/addr/be/wdata)
//   slave  : the environment (core execute stage plus data memory)
interface lsu_mem_stage_if;
    // Execute-stage request
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    // Writeback response
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    // Data-memory bus
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store unit after the ALU. Runs one data-memory access per
// request over a req/gnt/rvalid bus and returns sign/zero-extended load data.
// Ports:
//   clk   - core clock, rising edge
//   reset - asynchronous active-high reset
//   bus   - lsu_mem_stage_if.master (request, response, busy and memory bus)
// Parameters:
//   TIMEOUT_CYCLES - cycles spent in ADDR+RESP before the access aborts with error
// Build option:
//   LSU_MISALIGN_TRAP_EN - when defined, misaligned H/W accesses complete with
//   error and no bus cycle; otherwise the address is forced aligned.
module lsu_mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic             clk,
    input logic             reset,
    lsu_mem_stage_if.master bus
);

    typedef enum logic [1:0] {StIdle, StAddr, StResp, StDone} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [15:0] cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    // Request decode
    logic       illegal;
    logic       misalign_err;
    logic [1:0] req_off;
    logic [3:0] req_be;
    logic       timeout;
    logic [31:0] lane;
    logic [31:0] load_data;

    // 011, 110, 111 are never legal; stores have no unsigned variants
    assign illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11) ||
                     (bus.req_we && bus.req_funct3[2]);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_err = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                          ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    assign misalign_err = 1'b0;
`endif

    // Byte offset with misaligned H/W forced down to natural alignment
    always_comb begin
        req_off = bus.req_addr[1:0];
        req_be  = 4'b0001 << bus.req_addr[1:0];
        if (bus.req_funct3[1:0] == 2'b01) begin
            req_off = {bus.req_addr[1], 1'b0};
            req_be  = 4'b0011 << {bus.req_addr[1], 1'b0};
        end else if (bus.req_funct3[1:0] == 2'b10) begin
            req_off = 2'b00;
            req_be  = 4'b1111;
        end
    end

    assign timeout = (({16'd0, cnt_q} + 32'd1) == TIMEOUT_CYCLES);

    // Load lane extraction; funct3[2] selects zero extension
    assign lane = bus.mem_rdata >> {off_q, 3'b000};
    always_comb begin
        case (f3_q[1:0])
            2'b00:   load_data = {{24{~f3_q[2] & lane[7]}}, lane[7:0]};
            2'b01:   load_data = {{16{~f3_q[2] & lane[15]}}, lane[15:0]};
            default: load_data = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'd0;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    we_d  = bus.req_we;
                    f3_d  = bus.req_funct3;
                    off_d = req_off;
                    if (illegal || misalign_err) begin
                        state_d     = StDone;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d     = StAddr;
                        cnt_d       = 16'd0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.req_we;
                        mem_addr_d  = {bus.req_addr[31:2], 2'b00};
                        mem_be_d    = req_be;
                        mem_wdata_d = bus.req_wdata << {req_off, 3'b000};
                    end
                end
            end
            StAddr: begin
                cnt_d = cnt_q + 16'd1;
                if (timeout || bus.mem_gnt) begin
                    // Bus cycle ends either way; quiet the bus outputs
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 32'd0;
                    mem_be_d    = 4'd0;
                    mem_wdata_d = 32'd0;
                    if (timeout) begin
                        state_d     = StDone;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                cnt_d = cnt_q + 16'd1;
                if (bus.mem_rvalid) begin
                    state_d     = StDone;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? 32'd0 : load_data;
                end else if (timeout) begin
                    state_d     = StDone;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            f3_q        <= 3'd0;
            off_q       <= 2'd0;
            cnt_q       <= 16'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule
